// File: rtl/puf_tx_sched.sv
// puf_tx_sched: round-robin arbiter that captures a PUF response and streams it MSB-first over valid/ready.
// Define PUF_TX_HEADER_EN to prefix each frame with a byte holding the granted requester index.
module puf_tx_sched #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 264,
    parameter int BITS      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           grant,
    output logic                       tx_valid,
    output logic [BITS-1:0]            tx_data,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int COUNT = DATA_BITS / BITS;
    localparam int CW    = $clog2(COUNT + 1);
    localparam int SW    = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
`ifdef PUF_TX_HEADER_EN
        , HDR
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          last_q, last_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [SW-1:0]          sel;

    // Walk from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        sel = last_q;
        for (int i = N_REQ; i >= 1; i--)
            if (req[SW'((int'(last_q) + i) % N_REQ)]) sel = SW'((int'(last_q) + i) % N_REQ);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = '0;
        case (state_q)
            IDLE: if (|req) begin
                shift_d      = req_data[sel*DATA_BITS +: DATA_BITS];
                grant_d[sel] = 1'b1;
                last_d       = sel;
                cnt_d        = '0;
`ifdef PUF_TX_HEADER_EN
                state_d      = HDR;
`else
                state_d      = SEND;
`endif
            end
`ifdef PUF_TX_HEADER_EN
            HDR: if (tx_ready) state_d = SEND;
`endif
            SEND: if (tx_ready) begin
                shift_d = shift_q << BITS;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(COUNT - 1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= SW'(N_REQ - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
`ifdef PUF_TX_HEADER_EN
    assign tx_valid   = state_q == SEND || state_q == HDR;
    assign tx_data    = state_q == SEND ? shift_q[DATA_BITS-1 -: BITS] :
                        state_q == HDR  ? BITS'(last_q) : '0;
`else
    assign tx_valid   = state_q == SEND;
    assign tx_data    = state_q == SEND ? shift_q[DATA_BITS-1 -: BITS] : '0;
`endif
endmodule

// File: tb/tb_puf_tx_sched.sv
// tb_puf_tx_sched: scoreboard bench for puf_tx_sched; expected bytes queued per frame, checked at each handshake.
module tb_puf_tx_sched;
    localparam int N_REQ = 4;
    localparam int DATA_BITS = 264;
    localparam int BITS = 8;
    localparam int COUNT = DATA_BITS / BITS;

    logic                       clk = 0;
    logic                       rst = 1;
    logic [N_REQ-1:0]           req = '0;
    logic [N_REQ*DATA_BITS-1:0] req_data;
    logic [N_REQ-1:0]           grant;
    logic                       tx_valid;
    logic [BITS-1:0]            tx_data;
    logic                       tx_ready = 0;
    logic                       busy;
    logic                       frame_done;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [N_REQ-1:0] req;
        int               idx;
        bit               alt;
    } vec_t;
    vec_t tbl[8];

    puf_tx_sched #(.N_REQ(N_REQ), .DATA_BITS(DATA_BITS), .BITS(BITS)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(int r, int b);
        return 8'((r << 6) | (b + 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller sets req; this drives tx_ready and checks one whole frame from requester r.
    task automatic do_frame(input int r, input bit alt);
        int cyc;
        bit stalled;
        logic [7:0] held;
`ifdef PUF_TX_HEADER_EN
        exp_q.push_back(8'(r));
`endif
        for (int b = 0; b < COUNT; b++) exp_q.push_back(byte_of(r, b));
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (grant == '0 && cyc < 8);
        chk("grant", 32'(grant), 32'(1 << r));
        chk("valid_at_grant", 32'(tx_valid), 1);
        chk("busy_at_grant", 32'(busy), 1);
        stalled = 0;
        held = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (stalled) chk("stall_hold", 32'(tx_data), 32'(held));
            chk("valid_in_frame", 32'(tx_valid), 1);
            chk("no_done_in_frame", 32'(frame_done), 0);
            tx_ready = alt ? (cyc % 2 == 0) : 1'b1;
            if (tx_valid && tx_ready) chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            tick();
            cyc++;
            if (cyc == 1) chk("grant_pulse", 32'(grant), 0);
        end
        if (exp_q.size() > 0) begin
            chk("frame_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        chk("frame_done", 32'(frame_done), 1);
        chk("valid_at_done", 32'(tx_valid), 0);
        tick();
        chk("done_pulse", 32'(frame_done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("valid_gap", 32'(tx_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < N_REQ; r++)
            for (int b = 0; b < COUNT; b++)
                req_data[r*DATA_BITS + DATA_BITS - 1 - 8*b -: 8] = byte_of(r, b);
        tbl[0] = '{4'b1111, 0, 1'b0};
        tbl[1] = '{4'b1111, 1, 1'b0};
        tbl[2] = '{4'b1111, 2, 1'b1};
        tbl[3] = '{4'b1111, 3, 1'b0};
        tbl[4] = '{4'b1111, 0, 1'b0};
        tbl[5] = '{4'b1010, 1, 1'b1};
        tbl[6] = '{4'b1001, 3, 1'b0};
        tbl[7] = '{4'b0110, 1, 1'b0};

        req = 4'b1111;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        req = '0;
        rst = 0;
        tick();
        chk("idle_no_grant", 32'(grant), 0);

        req = 4'b0001;
        do_frame(0, 1'b0);
        req = '0;
        tick();
        chk("idle_after_single", 32'(busy), 0);

        req = 4'b0001;
        do_frame(0, 1'b1);
        req = '0;

        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            do_frame(tbl[i].idx, tbl[i].alt);
        end
        req = '0;

        // Abort a frame from requester 0 after ten bytes; only a fresh pointer regrants 0 over 2.
        req = 4'b0001;
        tx_ready = 1;
        begin
            int cyc = 0;
            do begin
                tick();
                cyc++;
            end while (grant == '0 && cyc < 8);
        end
        chk("abort_grant", 32'(grant), 1);
`ifdef PUF_TX_HEADER_EN
        chk("abort_hdr", 32'(tx_data), 0);
        tick();
`endif
        for (int k = 0; k < 10; k++) begin
            chk("abort_byte", 32'(tx_data), 32'(byte_of(0, k)));
            tick();
        end
        req = '0;
        rst = 1;
        tick();
        rst = 0;
        chk("abort_valid", 32'(tx_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(frame_done), 0);
        req = 4'b0101;
        do_frame(0, 1'b0);
        req = 4'b0100;
        do_frame(2, 1'b0);
        req = '0;
        tick();
        chk("final_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
